// File: rtl/exp_sub_pipe_pkg.sv
// rtl/exp_sub_pipe_pkg.sv - shared constants for the exponent subtract pipeline
//
// Purpose: carry-network encoding, default operand width and pipeline latency.
//   KILL / PROP / GEN : 2-bit kill/propagate/generate codes used by the prefix tree
//   EXP_SUB_WIDTH     : default operand width
//   EXP_SUB_LAT       : cycles from accepted operands to valid result
package exp_sub_pipe_pkg;

  localparam logic [1:0] KILL = 2'b00;
  localparam logic [1:0] PROP = 2'b01;
  localparam logic [1:0] GEN  = 2'b10;

  localparam int EXP_SUB_WIDTH = 8;
  localparam int EXP_SUB_LAT   = 3;

endpackage

// File: rtl/kpg_sub_cell.sv
// rtl/kpg_sub_cell.sv - one prefix combine node of the carry network
//
// Purpose: merges a higher span with the span directly below it.
// Ports:
//   hi_i  : K/P/G code of the upper (more significant) span
//   lo_i  : K/P/G code of the lower span
//   kpg_o : K/P/G code of the merged span
module kpg_sub_cell
  import exp_sub_pipe_pkg::*;
(
  input  logic [1:0] hi_i,
  input  logic [1:0] lo_i,
  output logic [1:0] kpg_o
);

  // A kill or generate in the upper span decides the carry on its own;
  // a propagate hands the decision to the lower span.
  assign kpg_o = (hi_i == PROP) ? lo_i : hi_i;

endmodule

// File: rtl/exp_sub_pipe.sv
// rtl/exp_sub_pipe.sv - three-stage a-b exponent subtractor with prefix carry tree
//
// Purpose: computes a - b as a + ~b + 1, its borrow, magnitude and swap flag.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   a, b                 : minuend / subtrahend (biased exponents)
//   out_valid / out_ready: result handshake
//   diff, borrow         : a - b modulo 2^WIDTH, a < b
//   abs_diff, swap       : |a - b| (alignment shift), operand swap request (= borrow)
module exp_sub_pipe
  import exp_sub_pipe_pkg::*;
#(
  parameter int WIDTH = EXP_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [WIDTH-1:0] abs_diff,
  output logic             swap
);

  localparam int LVLS = $clog2(WIDTH);

  logic                  en;
  logic                  v1_q, v2_q, v3_q;
  logic [WIDTH-1:0][1:0] init_kpg;
  logic [WIDTH-1:0][1:0] s1_pre_d, s1_pre_q;
  logic [WIDTH-1:0][1:0] s2_pre_d, s2_pre_q;
  logic [WIDTH-1:0]      p_d, s1_p_q, s2_p_q;
  logic [WIDTH-1:0]      carry, sum, mag;
  logic                  brw;
  logic [WIDTH-1:0]      diff_d, diff_q, abs_d, abs_q;
  logic                  borrow_d, borrow_q;

  // Single advance enable: the whole pipe moves unless a result is stuck at the output.
  assign en       = ~v3_q | out_ready;
  assign in_ready = en;

  assign p_d = a ^ ~b;

  // Bit 0 absorbs the carry-in of 1, so it can only generate or kill. Every
  // prefix therefore resolves to GEN or KILL and directly names the carry.
  always_comb begin
    init_kpg    = '0;
    init_kpg[0] = (a[0] | ~b[0]) ? GEN : KILL;
    for (int i = 1; i < WIDTH; i++) begin
      if (a[i] & ~b[i])      init_kpg[i] = GEN;
      else if (~a[i] & b[i]) init_kpg[i] = KILL;
      else                   init_kpg[i] = PROP;
    end
  end

  // Stage 1 combine: span 1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_span1
    if (i >= 1) begin : g_cell
      kpg_sub_cell u_cell (.hi_i(init_kpg[i]), .lo_i(init_kpg[i-1]), .kpg_o(s1_pre_d[i]));
    end else begin : g_pass
      assign s1_pre_d[i] = init_kpg[i];
    end
  end

  // Stage 2 combine: spans 2, 4, ... up to the full width (Kogge-Stone).
  for (genvar l = 1; l < LVLS; l++) begin : g_s2
    logic [WIDTH-1:0][1:0] lv_in;
    logic [WIDTH-1:0][1:0] lv_out;
    if (l == 1) begin : g_first
      assign lv_in = s1_pre_q;
    end else begin : g_next
      assign lv_in = g_s2[l-1].lv_out;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_cell
        kpg_sub_cell u_cell (.hi_i(lv_in[i]), .lo_i(lv_in[i-(1<<l)]), .kpg_o(lv_out[i]));
      end else begin : g_pass
        assign lv_out[i] = lv_in[i];
      end
    end
  end

  if (LVLS > 1) begin : g_s2_out
    assign s2_pre_d = g_s2[LVLS-1].lv_out;
  end else begin : g_s2_bypass
    assign s2_pre_d = s1_pre_q;
  end

  // Stage 3: carries from the finished prefixes, then sum, borrow and magnitude.
  // Invalid slots load zeros so the outputs read 0 whenever out_valid is low.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) carry[i] = (s2_pre_q[i-1] == GEN);
    sum      = s2_p_q ^ carry;
    brw      = (s2_pre_q[WIDTH-1] != GEN);
    mag      = brw ? (~sum + WIDTH'(1)) : sum;
    diff_d   = v2_q ? sum : '0;
    abs_d    = v2_q ? mag : '0;
    borrow_d = v2_q & brw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s1_pre_q <= '0;
      s1_p_q   <= '0;
      s2_pre_q <= '0;
      s2_p_q   <= '0;
      diff_q   <= '0;
      abs_q    <= '0;
      borrow_q <= 1'b0;
    end else if (en) begin
      v1_q     <= in_valid;
      s1_pre_q <= s1_pre_d;
      s1_p_q   <= p_d;
      v2_q     <= v1_q;
      s2_pre_q <= s2_pre_d;
      s2_p_q   <= s1_p_q;
      v3_q     <= v2_q;
      diff_q   <= diff_d;
      abs_q    <= abs_d;
      borrow_q <= borrow_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign abs_diff  = abs_q;
  assign borrow    = borrow_q;
  assign swap      = borrow_q;

endmodule

// File: tb/tb_exp_sub_pipe.sv
// tb/tb_exp_sub_pipe.sv - randomized and directed bench for exp_sub_pipe
module tb_exp_sub_pipe;
  import exp_sub_pipe_pkg::EXP_SUB_LAT;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic [W-1:0] ab;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic [W-1:0] abs_diff;
  logic         swap;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t exp_q[$];

  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_diff, hold_abs;
  logic         hold_br;

  exp_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow),
    .abs_diff(abs_diff), .swap(swap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer subtraction and comparison.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    int unsigned xi = x;
    int unsigned yi = y;
    e.br = (xi < yi);
    e.d  = W'(xi - yi);
    e.ab = e.br ? W'(yi - xi) : W'(xi - yi);
    return e;
  endfunction

  // Observes each upcoming clock edge while inputs and outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_diff", diff, hold_diff);
        check("hold_borrow", borrow, hold_br);
        check("hold_abs", abs_diff, hold_abs);
      end
      if (!out_valid) check("idle_zero", {diff, borrow, abs_diff, swap}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          check("diff", diff, e.d);
          check("borrow", borrow, e.br);
          check("abs_diff", abs_diff, e.ab);
          check("swap", swap, e.br);
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_diff    = diff;
      hold_br      = borrow;
      hold_abs     = abs_diff;
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // One pair into an empty pipe; the result must appear exactly EXP_SUB_LAT edges later.
  task automatic run_single(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] ed, input logic eb, input logic [W-1:0] ea);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; out_ready = 1'b1;
    for (int k = 1; k < EXP_SUB_LAT; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_early", out_valid, 0);
    end
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("lat_diff", diff, ed);
    check("lat_borrow", borrow, eb);
    check("lat_abs", abs_diff, ea);
    check("lat_swap", swap, eb);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int base;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_outs", {diff, borrow, abs_diff, swap}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("empty_in_ready", in_ready, 1);

    run_single(8'h50, 8'h30, 8'h20, 1'b0, 8'h20);
    run_single(8'h30, 8'h50, 8'hE0, 1'b1, 8'h20);
    run_single(8'hA5, 8'hA5, 8'h00, 1'b0, 8'h00);

    // Back-to-back extremes on consecutive cycles.
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h00; b = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_first", {diff, borrow, abs_diff}, {8'h01, 1'b1, 8'hFF});
    @(posedge clk); #1;
    check("b2b_second", {diff, borrow, abs_diff}, {8'hFF, 1'b0, 8'hFF});

    // Eight pairs with the output stalled on cycles 4..6.
    drain();
    sent = 0;
    base = n_out;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 8);
      a = W'($urandom); b = W'($urandom);
      #1;
      if (cyc == 4) check("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) sent++;
    end
    drain();
    check("stall_sent", sent, 8);
    check("stall_count", n_out - base, 8);

    // Reset with three results in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    a = 8'h55; b = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_outs", {diff, borrow, abs_diff, swap}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_empty", out_valid, 0);
    run_single(8'h7F, 8'h7F, 8'h00, 1'b0, 8'h00);

    // Random traffic with corners and random backpressure.
    for (int n = 0; n < 10000; n++) begin
      int kind;
      @(posedge clk); #1;
      kind = $urandom_range(0, 7);
      a = W'($urandom);
      b = W'($urandom);
      if (kind == 0) b = a;
      else if (kind == 1) begin
        a = ($urandom_range(0, 1) != 0) ? '1 : '0;
        b = ($urandom_range(0, 1) != 0) ? '1 : '0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_sub_pipe.md
EXP_SUB_PIPE -- requirements
Module: exp_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  WIDTH  minuend (biased exponent).
REQ-007 b  input  WIDTH  subtrahend (biased exponent).
REQ-008 out_valid  output  1  result fields valid.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 borrow  output  1  1 when a < b (unsigned).
REQ-012 abs_diff  output  WIDTH  |a - b|, the alignment shift amount.
REQ-013 swap  output  1  equals borrow; tells the mantissa path to swap operands.

Function
REQ-014 Subtraction SHALL be computed as a + ~b + 1 using a parallel-prefix kill/propagate/generate carry network with carry-in 1; borrow = NOT carry-out.
REQ-015 The datapath SHALL be a 3-stage pipeline: S1 registers the initial K/P/G terms and the span-1 combine; S2 registers the span-2 and span-4 combines (further log2(WIDTH) spans in S2 for WIDTH > 8); S3 registers diff, borrow, abs_diff and swap.
REQ-016 Latency SHALL be exactly 3 clk cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-017 abs_diff SHALL equal diff when borrow = 0, and the two's complement of diff when borrow = 1.
REQ-018 The global advance enable SHALL be en = ~out_valid | out_ready; in_ready = en, combinationally.
REQ-019 When en = 1, every stage's valid and payload shift forward one stage; when en = 0, all stage registers hold.
REQ-020 A transfer on the input with en = 1 and in_valid = 0 SHALL load a bubble (S1 valid = 0).
REQ-021 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-022 out_valid SHALL remain asserted and diff/borrow/abs_diff/swap SHALL remain stable while out_valid & ~out_ready.
REQ-023 Payload registers of invalid stages are don't-care internally, but outputs SHALL read 0 when out_valid = 0.
REQ-024 Simultaneous output acceptance and input acceptance in one cycle SHALL be lossless, with no duplication.
REQ-025 Operands a = b SHALL give diff = 0, borrow = 0, abs_diff = 0.

Reset
REQ-026 rst SHALL clear all stage valid bits and all output registers to 0 immediately, independent of clk.
REQ-027 Results in flight at rst assertion SHALL be discarded; the first input accepted after deassertion appears 3 cycles later.
REQ-028 in_ready SHALL be 1 while rst is deasserted and the pipe is empty.

Structure
REQ-029 A shared package SHALL hold the KPG 2-bit encoding constants (KILL, PROP, GEN), the default WIDTH, and the latency constant EXP_SUB_LAT = 3.
REQ-030 One sub-module, kpg_sub_cell, SHALL implement the prefix combine (current K/G overrides, P passes the lower span); it is instantiated as arrays per prefix level.
REQ-031 No multi-cycle or iterative arithmetic SHALL be used; pipeline registers only.

Verification
REQ-032 a = 0x50, b = 0x30, out_ready = 1 -> after 3 cycles diff = 0x20, borrow = 0, abs_diff = 0x20, swap = 0.
REQ-033 a = 0x30, b = 0x50 -> diff = 0xE0, borrow = 1, abs_diff = 0x20, swap = 1.
REQ-034 a = 0x00, b = 0xFF, then a = 0xFF, b = 0x00 back-to-back -> {0x01, 1, 0xFF}, then {0xFF, 0, 0xFF} on consecutive cycles.
REQ-035 Stream 8 pairs with out_ready low on cycles 4-6 -> no loss or duplication, outputs held during the stall, in_ready = 0 exactly when out_valid & ~out_ready.
REQ-036 Assert rst with 3 results in flight -> out_valid = 0 and outputs = 0 immediately; after release, a = 0x7F, b = 0x7F -> diff = 0x00, borrow = 0 at cycle 3.
REQ-037 Random 10k pairs against a reference model of a - b, including a == b and all-ones/all-zeros corners, with random out_ready -> all fields match, in order.
